// File: rtl/cache_bus_arbiter_if.sv
// Handshake bundle between the I/D cache sram-like ports, the arbiter and the AXI bridge.
// slave: the arbiter's view; master: the caches plus the bridge driving the arbiter.
interface cache_bus_arbiter_if;
   logic        i_req;
   logic        i_wr;
   logic [1:0]  i_size;
   logic [31:0] i_addr;
   logic [31:0] i_wdata;
   logic [31:0] i_rdata;
   logic        i_addr_ok;
   logic        i_data_ok;

   logic        d_req;
   logic        d_wr;
   logic [1:0]  d_size;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_addr_ok;
   logic        d_data_ok;

   logic        bus_req;
   logic        bus_wr;
   logic [1:0]  bus_size;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_addr_ok;
   logic        bus_data_ok;

   modport slave (
      input  i_req, i_wr, i_size, i_addr, i_wdata,
      output i_rdata, i_addr_ok, i_data_ok,
      input  d_req, d_wr, d_size, d_addr, d_wdata,
      output d_rdata, d_addr_ok, d_data_ok,
      output bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
      input  bus_rdata, bus_addr_ok, bus_data_ok
   );

   modport master (
      output i_req, i_wr, i_size, i_addr, i_wdata,
      input  i_rdata, i_addr_ok, i_data_ok,
      output d_req, d_wr, d_size, d_addr, d_wdata,
      input  d_rdata, d_addr_ok, d_data_ok,
      input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
      output bus_rdata, bus_addr_ok, bus_data_ok
   );
endinterface

// File: rtl/cache_bus_arbiter.sv
// Two-master (I-cache / D-cache) arbiter onto one sram-like bus, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; otherwise D always wins.
module cache_bus_arbiter (
   input logic                 clk,
   input logic                 rst,
   cache_bus_arbiter_if.slave  cbi
);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      GNT_I   = 2'b01,
      GNT_D   = 2'b10,
      ILLEGAL = 2'b11
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   addr_rcv;
   logic   pick_d;
   logic   req_i_gnt;
   logic   req_d_gnt;

`ifdef ARB_ROUND_ROBIN_EN
   logic rr_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rr_last <= 1'b0;
      else if (state == IDLE && state_nxt == GNT_D)
         rr_last <= 1'b1;
      else if (state == IDLE && state_nxt == GNT_I)
         rr_last <= 1'b0;
   end

   always_comb pick_d = ~rr_last;
`else
   always_comb pick_d = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // data_ok takes priority so a same-cycle addr_ok/data_ok leaves the flag clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         addr_rcv <= 1'b0;
      else if (cbi.bus_data_ok)
         addr_rcv <= 1'b0;
      else if (cbi.bus_req && cbi.bus_addr_ok)
         addr_rcv <= 1'b1;
   end

   always_comb begin
      req_i_gnt = (state == GNT_I) && cbi.i_req && !addr_rcv;
      req_d_gnt = (state == GNT_D) && cbi.d_req && !addr_rcv;
   end

   always_comb begin
      state_nxt     = state;
      cbi.bus_req   = 1'b0;
      cbi.bus_wr    = 1'b0;
      cbi.bus_size  = '0;
      cbi.bus_addr  = '0;
      cbi.bus_wdata = '0;
      cbi.i_addr_ok = 1'b0;
      cbi.i_data_ok = 1'b0;
      cbi.d_addr_ok = 1'b0;
      cbi.d_data_ok = 1'b0;
      case (state)
         IDLE: begin
            if (cbi.d_req && cbi.i_req)
               state_nxt = pick_d ? GNT_D : GNT_I;
            else if (cbi.d_req)
               state_nxt = GNT_D;
            else if (cbi.i_req)
               state_nxt = GNT_I;
         end
         GNT_I: begin
            cbi.bus_req   = req_i_gnt;
            cbi.bus_wr    = cbi.i_wr;
            cbi.bus_size  = cbi.i_size;
            cbi.bus_addr  = cbi.i_addr;
            cbi.bus_wdata = cbi.i_wdata;
            cbi.i_addr_ok = req_i_gnt && cbi.bus_addr_ok;
            cbi.i_data_ok = cbi.bus_data_ok;
            // release an unaccepted request; once the address is taken, wait for data
            if (cbi.bus_data_ok)
               state_nxt = IDLE;
            else if (!cbi.i_req && !addr_rcv && !cbi.bus_addr_ok)
               state_nxt = IDLE;
         end
         GNT_D: begin
            cbi.bus_req   = req_d_gnt;
            cbi.bus_wr    = cbi.d_wr;
            cbi.bus_size  = cbi.d_size;
            cbi.bus_addr  = cbi.d_addr;
            cbi.bus_wdata = cbi.d_wdata;
            cbi.d_addr_ok = req_d_gnt && cbi.bus_addr_ok;
            cbi.d_data_ok = cbi.bus_data_ok;
            if (cbi.bus_data_ok)
               state_nxt = IDLE;
            else if (!cbi.d_req && !addr_rcv && !cbi.bus_addr_ok)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cbi.i_rdata = cbi.bus_rdata;
      cbi.d_rdata = cbi.bus_rdata;
   end

endmodule
